// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and widths for the data-memory responder
package dmem_pkg;
   localparam int DATA_W     = 64;
   localparam int BYTE_OFS_W = 3;
   localparam int WCNT_W     = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_WAIT = S_WAIT,
      ST_RESP = S_RESP
   } state_t;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - doubleword storage with synchronous write and registered read
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 128,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory for the CPU load/store port
// Optional bad-access reporting enabled by defining DMEM_FAULT_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_STATES = 2,
   parameter int DATA_W      = 64
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [63:0]       mem_address,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic              control_memwrite,
   input  logic              control_memread,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_ready,
   output logic              mem_fault
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t              r_state;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [63:0]         r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_wr;
   logic                r_rd;

   logic                w_req;
   logic                w_in_idle;
   logic [63:0]         w_acc_addr;
   logic [DATA_W-1:0]   w_acc_data;
   logic                w_acc_wr;
   logic                w_acc_rd;
   logic                w_fault;
   logic                w_enter_resp;
   logic [DATA_W-1:0]   w_rdata;

   assign w_req     = control_memread | control_memwrite;
   assign w_in_idle = (r_state == ST_IDLE);

   // With zero wait states the array is accessed on the capture edge itself,
   // so the live request is used until the capture registers take over.
   assign w_acc_addr = w_in_idle ? mem_address      : r_addr;
   assign w_acc_data = w_in_idle ? mem_data_in      : r_data;
   assign w_acc_wr   = w_in_idle ? control_memwrite : r_wr;
   assign w_acc_rd   = w_in_idle ? (control_memread & ~control_memwrite) : r_rd;

`ifdef DMEM_FAULT_EN
   assign w_fault = (w_acc_addr[BYTE_OFS_W-1:0] != '0) ||
                    (w_acc_addr >= 64'(DEPTH_WORDS * 8));
`else
   logic w_unused_addr;
   assign w_fault       = 1'b0;
   assign w_unused_addr = ^{w_acc_addr[BYTE_OFS_W-1:0], w_acc_addr[63:BYTE_OFS_W+IDX_W]};
`endif

   assign w_enter_resp = ~RESET &
                         ((w_in_idle && w_req && (WAIT_STATES == 0)) ||
                          (r_state == ST_WAIT && r_wcnt == '0));

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (CLOCK),
      .i_we    (w_enter_resp & w_acc_wr & ~w_fault),
      .i_re    (w_enter_resp & w_acc_rd),
      .i_idx   (w_acc_addr[BYTE_OFS_W +: IDX_W]),
      .i_wdata (w_acc_data),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_wcnt       <= '0;
         mem_ready    <= 1'b0;
         mem_fault    <= 1'b0;
         mem_data_out <= '0;
      end else begin
         mem_ready <= 1'b0;
         mem_fault <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr <= mem_address;
                  r_data <= mem_data_in;
                  r_wr   <= control_memwrite;
                  r_rd   <= control_memread & ~control_memwrite;
                  if (WAIT_STATES == 0) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_WAIT;
                     r_wcnt  <= WCNT_W'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (r_wcnt == '0) r_state <= ST_RESP;
               else              r_wcnt  <= r_wcnt - 1'b1;
            end
            ST_RESP: begin
               // Array data was registered on the edge that entered RESP.
               mem_ready <= 1'b1;
               mem_fault <= w_fault;
               if (r_rd) mem_data_out <= w_fault ? '0 : w_rdata;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized model-checked bench for dmem_responder
module tb_dmem_responder;

   localparam int DEPTH = 128;
`ifdef DMEM_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] addr_q [2];
   logic [63:0] din_q  [2];
   logic        wr_q   [2];
   logic        rd_q   [2];
   logic [63:0] dout   [2];
   logic        rdy    [2];
   logic        flt    [2];

   logic [63:0] mdl_mem [2][DEPTH];
   logic [63:0] mdl_out [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .DATA_W(64)) u_dut0 (
      .CLOCK(clk), .RESET(rst), .mem_address(addr_q[0]), .mem_data_in(din_q[0]),
      .control_memwrite(wr_q[0]), .control_memread(rd_q[0]),
      .mem_data_out(dout[0]), .mem_ready(rdy[0]), .mem_fault(flt[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .DATA_W(64)) u_dut1 (
      .CLOCK(clk), .RESET(rst), .mem_address(addr_q[1]), .mem_data_in(din_q[1]),
      .control_memwrite(wr_q[1]), .control_memread(rd_q[1]),
      .mem_data_out(dout[1]), .mem_ready(rdy[1]), .mem_fault(flt[1]));

   function automatic int ws(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic access(input int d, input bit rd, input bit wr, input logic [63:0] addr,
                         input logic [63:0] data, input bit scramble, input string tag);
      bit flt_e;
      bit seen;
      int idx;
      int lat;
      flt_e = FAULT_EN && ((addr % 8) != 0 || addr >= 64'(DEPTH * 8));
      idx   = int'((addr / 8) % DEPTH);
      @(posedge clk); #1;
      addr_q[d] = addr; din_q[d] = data; rd_q[d] = rd; wr_q[d] = wr;
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (c == 1 && scramble) begin
            addr_q[d] = addr ^ 64'h48;
            din_q[d]  = ~data;
         end
         if (rdy[d]) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      rd_q[d] = 1'b0;
      wr_q[d] = 1'b0;
      if (wr) begin
         if (!flt_e) mdl_mem[d][idx] = data;
      end else if (rd) begin
         mdl_out[d] = flt_e ? 64'h0 : mdl_mem[d][idx];
      end
      check({tag, ".latency"}, 64'(lat), 64'(ws(d) + 2));
      check({tag, ".fault"}, 64'(flt[d]), 64'(flt_e));
      check({tag, ".data"}, dout[d], mdl_out[d]);
      @(posedge clk); #1;
      check({tag, ".pulse"}, 64'(rdy[d]), 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] a;
      logic [63:0] v;
      int          r;
      for (int d = 0; d < 2; d++) begin
         addr_q[d] = '0; din_q[d] = '0; wr_q[d] = 1'b0; rd_q[d] = 1'b0;
         mdl_out[d] = '0;
         for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset.ready", 64'(rdy[d]), 64'h0);
         check("reset.fault", 64'(flt[d]), 64'h0);
         check("reset.data", dout[d], 64'h0);
      end
      rst = 1'b0;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            access(d, 1'b0, 1'b1, 64'(i * 8), 64'h0, 1'b0, "fill");

      access(0, 1'b0, 1'b1, 64'h28, 64'hDEADBEEF_CAFEF00D, 1'b0, "t2.store");
      access(0, 1'b1, 1'b0, 64'h28, 64'h0, 1'b0, "t2.load");

      // Reset held two cycles while a store to 0x10 sits in WAIT.
      @(posedge clk); #1;
      addr_q[0] = 64'h10; din_q[0] = 64'hAAAA_5555_1234_8765; wr_q[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      wr_q[0] = 1'b0;
      @(posedge clk); #1;
      check("t1.ready_in_reset", 64'(rdy[0]), 64'h0);
      @(posedge clk); #1;
      check("t1.data_in_reset", dout[0], 64'h0);
      rst = 1'b0;
      mdl_out[0] = 64'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t1.no_late_ready", 64'(rdy[0]), 64'h0);
      end
      access(0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, "t1.load");

      access(1, 1'b0, 1'b1, 64'h0, 64'h1234, 1'b0, "t3.store");
      access(1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, "t3.load");

      access(0, 1'b1, 1'b0, 64'h28, 64'h0, 1'b0, "t4.preload");
      access(0, 1'b1, 1'b1, 64'h30, 64'h55, 1'b0, "t4.both");
      access(0, 1'b1, 1'b0, 64'h30, 64'h0, 1'b0, "t4.load");

      access(0, 1'b0, 1'b1, 64'h8, 64'h0BAD_F00D_1111_2222, 1'b1, "t5.store");
      access(0, 1'b1, 1'b0, 64'h8, 64'h0, 1'b0, "t5.load8");
      access(0, 1'b1, 1'b0, 64'h40, 64'h0, 1'b0, "t5.load40");

`ifdef DMEM_FAULT_EN
      access(0, 1'b1, 1'b0, 64'h0C, 64'h0, 1'b0, "t6.misaligned");
      access(0, 1'b0, 1'b1, 64'h400, 64'h7777_7777_7777_7777, 1'b0, "t6.range_store");
      access(0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, "t6.load0");
`else
      access(0, 1'b1, 1'b0, 64'h408, 64'h0, 1'b0, "t6.alias");
`endif

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 7))
            0:       a = {$urandom, $urandom};
            1:       a = 64'($urandom_range(0, DEPTH * 8 - 1));
            default: a = 64'($urandom_range(0, DEPTH - 1)) * 8;
         endcase
         v = {$urandom, $urandom};
         access(n % 2, (r < 5) || (r == 9), r >= 5, a, v, 1'($urandom_range(0, 1)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
